// File: rtl/ub_pkg.sv
// Shared types and widths for the unified-buffer skew collector and its row FIFO.
package ub_pkg;

    localparam int UB_ELEM_W = 16;
    localparam int UB_ROW_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } col_state_t;

endpackage

// File: rtl/ub_row_fifo.sv
// Small show-ahead synchronous FIFO for completed rows; the head entry is readable while not empty.
// Writes are refused when full unless a pop happens in the same cycle.
module ub_row_fifo
    import ub_pkg::*;
#(
    parameter int WIDTH = UB_ROW_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_entries [DEPTH];

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] r_entry;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_entry <= '0;
                end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_entry <= i_push_data;
                end
            end
            assign w_entries[gi] = r_entry;
        end
    endgenerate

    assign o_head_data = w_entries[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ub_skew_collector.sv
// Re-pairs the staggered two-lane unified-buffer stream into 32-bit rows and queues them for downstream.
// Optional build macro UB_SKEW_COLLECTOR_TRANSPOSE_EN adds col_transpose_in to swap the row halves.
module ub_skew_collector
    import ub_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ROW_LIMIT_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UB_ELEM_W-1:0]   ub_data_1_in,
    input  logic [UB_ELEM_W-1:0]   ub_data_2_in,
    input  logic                   ub_valid_1_in,
    input  logic                   ub_valid_2_in,
    input  logic                   col_start_in,
    input  logic [ROW_LIMIT_W-1:0] col_num_rows_in,
`ifdef UB_SKEW_COLLECTOR_TRANSPOSE_EN
    input  logic                   col_transpose_in,
`endif
    output logic [UB_ROW_W-1:0]    row_data_out,
    output logic                   row_valid_out,
    input  logic                   row_ready_in,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   skew_err_out,
    output logic                   ovf_err_out
);

    col_state_t             r_state;
    logic [ROW_LIMIT_W-1:0] r_rows_left;
    logic [UB_ELEM_W-1:0]   r_hold;
    logic                   r_hold_v;
    logic                   r_skew_err;
    logic                   r_ovf_err;
    logic                   r_done;

    logic                   w_collect;
    logic                   w_pair;
    logic                   w_skew;
    logic                   w_pop;
    logic                   w_ovf;
    logic                   w_push;
    logic                   w_full;
    logic                   w_empty;
    logic [UB_ROW_W-1:0]    w_head;
    logic [UB_ROW_W-1:0]    w_row_out;

    assign w_collect = (r_state == COLLECT);
    assign w_pair    = w_collect && ub_valid_2_in && r_hold_v;
    // Lane 2 without a hold, or a hold left unclaimed, are both pairing faults.
    assign w_skew    = w_collect && (ub_valid_2_in != r_hold_v);
    assign w_pop     = !w_empty && row_ready_in;
    assign w_ovf     = w_pair && w_full && !w_pop;
    assign w_push    = w_pair && !w_ovf;

    ub_row_fifo #(
        .WIDTH (UB_ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({ub_data_2_in, r_hold}),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rows_left <= '0;
            r_hold      <= '0;
            r_hold_v    <= 1'b0;
            r_skew_err  <= 1'b0;
            r_ovf_err   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (col_start_in) begin
                        r_rows_left <= col_num_rows_in;
                        r_skew_err  <= 1'b0;
                        r_ovf_err   <= 1'b0;
                        r_hold_v    <= 1'b0;
                        r_state     <= (col_num_rows_in == '0) ? DRAIN : COLLECT;
                    end
                end
                COLLECT: begin
                    r_hold_v <= ub_valid_1_in;
                    if (ub_valid_1_in) begin
                        r_hold <= ub_data_1_in;
                    end
                    if (w_skew) begin
                        r_skew_err <= 1'b1;
                    end
                    if (w_ovf) begin
                        r_ovf_err <= 1'b1;
                    end
                    // Dropped rows still count toward the programmed total.
                    if (w_pair) begin
                        r_rows_left <= r_rows_left - ROW_LIMIT_W'(1);
                        if (r_rows_left == ROW_LIMIT_W'(1)) begin
                            r_state  <= DRAIN;
                            r_hold_v <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef UB_SKEW_COLLECTOR_TRANSPOSE_EN
    logic r_transpose;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_transpose <= 1'b0;
        end else if ((r_state == IDLE) && col_start_in) begin
            r_transpose <= col_transpose_in;
        end
    end

    assign w_row_out = r_transpose ? {w_head[UB_ELEM_W-1:0], w_head[UB_ROW_W-1:UB_ELEM_W]} : w_head;
`else
    assign w_row_out = w_head;
`endif

    assign row_data_out  = w_empty ? '0 : w_row_out;
    assign row_valid_out = !w_empty;
    assign busy_out      = (r_state != IDLE);
    assign done_out      = r_done;
    assign skew_err_out  = r_skew_err;
    assign ovf_err_out   = r_ovf_err;

endmodule
